// File: rtl/octal_grant_if.sv
// Grant-decoder bus: code/valid/ack from the encoder side, one-hot grant and status back.
// The master side drives the code and ack; the slave side is the decoder.
interface octal_grant_if;
    logic       x;
    logic       y;
    logic       z;
    logic       v;
    logic       ack;
    logic [7:0] d;
    logic [2:0] code_q;
    logic       busy;
    logic       done;
    logic       timeout;

    modport master (
        output x, y, z, v, ack,
        input  d, code_q, busy, done, timeout
    );

    modport slave (
        input  x, y, z, v, ack,
        output d, code_q, busy, done, timeout
    );
endinterface

// File: rtl/octal_grant_decoder.sv
// Registered 3-to-8 grant decoder with minimum hold and ack-driven release.
// Optional ack timeout is enabled by defining OCT_GRANT_TIMEOUT_EN.
module octal_grant_decoder #(
    parameter int HOLD    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    octal_grant_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    if (HOLD < 1 || HOLD > 15) begin : g_bad_hold
        $error("HOLD out of range 1..15");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("TIMEOUT out of range 1..255");
    end

    function automatic logic [7:0] onehot(input logic [2:0] code);
        onehot = 8'h01 << code;
    endfunction

    state_t     state_r;
    state_t     next_state_s;
    logic [3:0] hold_cnt_r;
    logic [3:0] next_hold_s;
    logic [7:0] d_r;
    logic [7:0] next_d_s;
    logic [2:0] code_r;
    logic [2:0] next_code_s;
    logic       busy_r;
    logic       done_r;
    logic       next_done_s;
    logic       timeout_r;
    logic       next_timeout_s;
`ifdef OCT_GRANT_TIMEOUT_EN
    logic [7:0] wait_cnt_r;
    logic [7:0] next_wait_s;
`endif

    // Next-state and next-output logic for the grant FSM
    always_comb begin
        next_state_s   = state_r;
        next_hold_s    = hold_cnt_r;
        next_d_s       = d_r;
        next_code_s    = code_r;
        next_done_s    = 1'b0;
        next_timeout_s = 1'b0;
`ifdef OCT_GRANT_TIMEOUT_EN
        next_wait_s    = wait_cnt_r;
`endif
        case (state_r)
            IDLE: begin
                next_d_s = 8'h00;
                if (bus.v) begin
                    next_code_s  = {bus.x, bus.y, bus.z};
                    next_d_s     = onehot({bus.x, bus.y, bus.z});
                    next_hold_s  = 4'(HOLD - 1);
`ifdef OCT_GRANT_TIMEOUT_EN
                    next_wait_s  = 8'd0;
`endif
                    next_state_s = GRANT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            GRANT: begin
                if (hold_cnt_r != 4'd0) begin
                    next_hold_s = hold_cnt_r - 4'd1;
                end else if (bus.ack) begin
                    next_d_s     = 8'h00;
                    next_done_s  = 1'b1;
                    next_state_s = RELEASE;
                end else begin
`ifdef OCT_GRANT_TIMEOUT_EN
                    // The wait window spans TIMEOUT full cycles after the hold, so the
                    // forced release lands HOLD+TIMEOUT cycles after the grant started.
                    if (wait_cnt_r == 8'(TIMEOUT)) begin
                        next_d_s       = 8'h00;
                        next_timeout_s = 1'b1;
                        next_state_s   = RELEASE;
                    end else begin
                        next_wait_s = wait_cnt_r + 8'd1;
                    end
`else
                    next_state_s = GRANT;
`endif
                end
            end
            RELEASE: begin
                next_d_s     = 8'h00;
                next_state_s = IDLE;
            end
            default: begin
                next_d_s     = 8'h00;
                next_state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            hold_cnt_r <= 4'd0;
            d_r        <= 8'h00;
            code_r     <= 3'b000;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            timeout_r  <= 1'b0;
`ifdef OCT_GRANT_TIMEOUT_EN
            wait_cnt_r <= 8'd0;
`endif
        end else begin
            state_r    <= next_state_s;
            hold_cnt_r <= next_hold_s;
            d_r        <= next_d_s;
            code_r     <= next_code_s;
            busy_r     <= (next_state_s != IDLE);
            done_r     <= next_done_s;
            timeout_r  <= next_timeout_s;
`ifdef OCT_GRANT_TIMEOUT_EN
            wait_cnt_r <= next_wait_s;
`endif
        end
    end

    assign bus.d       = d_r;
    assign bus.code_q  = code_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
`ifdef OCT_GRANT_TIMEOUT_EN
    assign bus.timeout = timeout_r;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule
